mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequencer between the multicycle control unit and the 32-bit data memory for byte/halfword/word loads and stores. The memory is word-addressed, so the block extracts lanes on loads and does read-modify-write for sub-word stores. It also drives the size selector that the load-size datapath consumes. Loads are zero-extended; lanes are little-endian.

Parameters:
MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after mem_addr is presented
ADDR_W, 32, address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request strobe, sampled in IDLE only
is_store  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 treated as word
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-justified
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  load result, zero-extended
error  out  1  one-cycle misalignment pulse (see Optional Feature)
load_sel  out  2  registered copy of size for the load-size datapath
mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
mem_wr  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, error, mem_wr = 0; rdata, mem_addr, mem_wdata = 0; load_sel=2'b10; wait counter = 0. mem_wr drops immediately, with no partial-write completion.
- States: IDLE, RD, WR, FIN.
- IDLE: on a start=1 edge, latch is_store, size, addr, byte offset addr[1:0] and wdata. Latch load_sel=size, with 11 mapped to 10.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: mem_addr driven, mem_wr=0. Counter counts MEM_LAT cycles. On the edge ending the last RD cycle, capture mem_rdata into word_buf.
  - Load: go to FIN, and rdata updates on the same edge.
  - Store: go to WR.
- Load extraction: byte = word_buf[8*off+7 : 8*off]; half = word_buf[16*off[1]+15 : 16*off[1]]; word = word_buf. Upper bits are 0.
- WR: exactly one cycle with mem_wr=1, mem_addr as latched, mem_wdata = merged word, then go to FIN.
  - Byte store: replaces lane off with wdata[7:0].
  - Half store: replaces half off[1] with wdata[15:0].
  - Word store: writes wdata.
  - Untouched lanes come from word_buf.
- FIN: done=1 for one cycle, then IDLE. busy falls on the same edge.
- Latency, counted in edges after the start-sampling edge, to the cycle where done=1:
  - load: MEM_LAT+1
  - word store: 2
  - sub-word store: MEM_LAT+2
- start while busy is ignored, with no queueing. start in FIN is ignored; start is accepted on the next IDLE cycle.
- rdata holds its value until the next load completes. Stores never change rdata.
- Without the macro, error is constantly 0.

Optional Feature:
Macro MISALIGN_CHECK_EN.
- Defined: in IDLE, start with (size=01 and addr[0]=1) or (size=1x and addr[1:0]!=0) raises no memory access. Next state is FIN with error=1 and done=1 in the same cycle. rdata and memory are unchanged.
- Not defined: low address bits beyond the access size are ignored. Half uses off[1]; word uses offset 0. error is tied 0.

Test Plan:
- MEM_LAT=1, mem[0x100]=0xAABBCCDD; load byte addr 0x102 -> done 2 cycles after start, rdata=0x000000BB, mem_wr never high, load_sel=00.
- Same memory; load half addr 0x102 -> rdata=0x0000AABB; load word 0x100 -> rdata=0xAABBCCDD.
- Store half wdata=0x99991234 at 0x102 -> one mem_wr cycle with mem_wdata=0x1234CCDD, done at cycle 3; store word 0x11223344 at 0x104 -> mem_wr at cycle 1, done at cycle 2, no RD state.
- MEM_LAT=3, load byte 0x101 -> done at cycle 4, rdata=0x000000CC; start pulsed during RD is ignored and no second access occurs.
- Reset asserted during WR -> mem_wr=0 immediately, all outputs at reset values, busy=0; a new request after release completes normally.
- With MISALIGN_CHECK_EN: load half at 0x101 -> error=1 and done=1 at cycle 1, no memory access, rdata unchanged. Without the macro: same request -> rdata=0x0000CCDD, error=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the control unit, mem_access_ctrl and the word-addressed data memory.
// master: control-unit side (also returns mem_rdata on behalf of the memory); slave: the sequencer.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              error;
  logic [1:0]        load_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output start, is_store, size, addr, wdata, mem_rdata,
    input  busy, done, rdata, error, load_sel, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  start, is_store, size, addr, wdata, mem_rdata,
    output busy, done, rdata, error, load_sel, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store sequencer for a word-addressed 32-bit memory (little-endian lanes,
// zero-extended loads, read-modify-write sub-word stores). Optional macro: MISALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  // Zero-extended lane extraction; size 11 behaves as word.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off);
    logic [31:0] res;
    res = 32'h0000_0000;
    case (sz)
      2'b00:   res = {24'h00_0000, word[{off, 3'b000} +: 8]};
      2'b01:   res = {16'h0000, word[{off[1], 4'b0000} +: 16]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Sub-word merge into the word just read; word stores never come through here.
  function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                             input logic [15:0] wd,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = old;
    case (sz)
      2'b00:   res[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = wd;
      default: res = old;
    endcase
    return res;
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic res;
    case (sz)
      2'b00:   res = 1'b0;
      2'b01:   res = off[0];
      default: res = (off != 2'b00);
    endcase
    return res;
  endfunction
`endif

  logic [1:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              is_store_r, is_store_s;
  logic [1:0]        size_r, size_s;
  logic [1:0]        off_r, off_s;
  logic [15:0]       wdata_r, wdata_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic [31:0]       rdata_r, rdata_s;
  logic [1:0]        load_sel_r, load_sel_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_wr_r, mem_wr_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic              misalign_s;

  // Misalignment detection on the incoming request.
  always_comb begin
`ifdef MISALIGN_CHECK_EN
    misalign_s = is_misaligned(bus.size, bus.addr[1:0]);
`else
    misalign_s = 1'b0;
`endif
  end

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    is_store_s  = is_store_r;
    size_s      = size_r;
    off_s       = off_r;
    wdata_s     = wdata_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    error_s     = 1'b0;
    rdata_s     = rdata_r;
    load_sel_s  = load_sel_r;
    mem_addr_s  = mem_addr_r;
    mem_wr_s    = 1'b0;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          is_store_s = bus.is_store;
          size_s     = bus.size;
          off_s      = bus.addr[1:0];
          wdata_s    = bus.wdata[15:0];
          load_sel_s = (bus.size == 2'b11) ? 2'b10 : bus.size;
          busy_s     = 1'b1;
          cnt_s      = {CNT_W{1'b0}};
          if (misalign_s) begin
            state_s = ST_FIN;
            done_s  = 1'b1;
            error_s = 1'b1;
          end else begin
            mem_addr_s = {bus.addr[ADDR_W-1:2], 2'b00};
            // Word stores need no read: go straight to the write cycle.
            if (bus.is_store && bus.size[1]) begin
              state_s     = ST_WR;
              mem_wr_s    = 1'b1;
              mem_wdata_s = bus.wdata;
            end else begin
              state_s = ST_RD;
            end
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_RD: begin
        if (cnt_r == CNT_LAST) begin
          if (is_store_r) begin
            state_s     = ST_WR;
            mem_wr_s    = 1'b1;
            mem_wdata_s = merge_lane(bus.mem_rdata, wdata_r, size_r, off_r);
          end else begin
            state_s = ST_FIN;
            done_s  = 1'b1;
            rdata_s = extract_lane(bus.mem_rdata, size_r, off_r);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WR: begin
        state_s = ST_FIN;
        done_s  = 1'b1;
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops mem_wr without completing a write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      is_store_r  <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      wdata_r     <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      load_sel_r  <= 2'b10;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wr_r    <= 1'b0;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      is_store_r  <= is_store_s;
      size_r      <= size_s;
      off_r       <= off_s;
      wdata_r     <= wdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      rdata_r     <= rdata_s;
      load_sel_r  <= load_sel_s;
      mem_addr_r  <= mem_addr_s;
      mem_wr_r    <= mem_wr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;
  assign bus.rdata     = rdata_r;
  assign bus.load_sel  = load_sel_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: two sequencers (MEM_LAT=1 and MEM_LAT=3) driven with the same directed requests.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_mem = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rst_chk = 1'b0;
  logic        end_chk = 1'b0;
  logic        tmo_req = 1'b0;
  logic        tmo_seen = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus_a ();
  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus_b ();

  mem_access_ctrl #(.MEM_LAT(1), .ADDR_W(ADDR_W)) dut_a (.clock(clk), .reset(rst_n), .bus(bus_a.slave));
  mem_access_ctrl #(.MEM_LAT(3), .ADDR_W(ADDR_W)) dut_b (.clock(clk), .reset(rst_n), .bus(bus_b.slave));

  assign bus_a.start = start;    assign bus_b.start = start;
  assign bus_a.is_store = is_store; assign bus_b.is_store = is_store;
  assign bus_a.size = size;      assign bus_b.size = size;
  assign bus_a.addr = addr;      assign bus_b.addr = addr;
  assign bus_a.wdata = wdata;    assign bus_b.wdata = wdata;

  logic [1:0]  busy_v, done_v, err_v, wr_v;
  logic [31:0] rd_v [2];
  logic [31:0] maddr_v [2];
  logic [31:0] mwd_v [2];
  logic [1:0]  sel_v [2];
  assign busy_v = {bus_b.busy, bus_a.busy};
  assign done_v = {bus_b.done, bus_a.done};
  assign err_v  = {bus_b.error, bus_a.error};
  assign wr_v   = {bus_b.mem_wr, bus_a.mem_wr};
  assign rd_v[0] = bus_a.rdata;     assign rd_v[1] = bus_b.rdata;
  assign maddr_v[0] = bus_a.mem_addr; assign maddr_v[1] = bus_b.mem_addr;
  assign mwd_v[0] = bus_a.mem_wdata; assign mwd_v[1] = bus_b.mem_wdata;
  assign sel_v[0] = bus_a.load_sel; assign sel_v[1] = bus_b.load_sel;

  // Memory models: instance 0 answers combinationally, instance 1 through a 2-stage pipe (3 cycles total).
  logic [31:0] mem [2][256];
  logic [31:0] pipe_b [2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) mem[i][j] <= 32'h0;
      mem[0][8'h40] <= 32'hAABBCCDD;
      mem[1][8'h40] <= 32'hAABBCCDD;
    end else begin
      for (int i = 0; i < 2; i++)
        if (wr_v[i]) mem[i][maddr_v[i][9:2]] <= mwd_v[i];
    end
    pipe_b[0] <= mem[1][maddr_v[1][9:2]];
    pipe_b[1] <= pipe_b[0];
  end
  assign bus_a.mem_rdata = mem[0][maddr_v[0][9:2]];
  assign bus_b.mem_rdata = pipe_b[1];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  sel;
    int          done_cyc;
  } exp_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  exp_t exp_q [2][$];
  wr_t  wr_q  [2][$];

  function automatic void chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, inst, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever a DUT writes memory or signals done.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (tmo_req && !tmo_seen) begin
      tmo_seen = 1'b1;
      chk("wait_timeout", 0, 32'd1, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      if (rst_chk) begin
        chk("rst_busy", i, {31'd0, busy_v[i]}, 32'd0);
        chk("rst_done", i, {31'd0, done_v[i]}, 32'd0);
        chk("rst_error", i, {31'd0, err_v[i]}, 32'd0);
        chk("rst_mem_wr", i, {31'd0, wr_v[i]}, 32'd0);
        chk("rst_rdata", i, rd_v[i], 32'd0);
        chk("rst_mem_addr", i, maddr_v[i], 32'd0);
        chk("rst_mem_wdata", i, mwd_v[i], 32'd0);
        chk("rst_load_sel", i, {30'd0, sel_v[i]}, 32'd2);
      end
      if (wr_v[i]) begin
        if (wr_q[i].size() == 0) begin
          chk("unexpected_write", i, maddr_v[i], 32'hFFFF_FFFF);
        end else begin
          w = wr_q[i].pop_front();
          chk("mem_addr", i, maddr_v[i], w.a);
          chk("mem_wdata", i, mwd_v[i], w.d);
        end
      end
      if (err_v[i] && !done_v[i]) chk("error_without_done", i, 32'd1, 32'd0);
      if (done_v[i]) begin
        if (exp_q[i].size() == 0) begin
          chk("unexpected_done", i, rd_v[i], 32'hFFFF_FFFF);
        end else begin
          e = exp_q[i].pop_front();
          chk("rdata", i, rd_v[i], e.rdata);
          chk("error", i, {31'd0, err_v[i]}, {31'd0, e.err});
          chk("load_sel", i, {30'd0, sel_v[i]}, {30'd0, e.sel});
          chk("done_cycle", i, cyc, e.done_cyc);
          chk("busy_at_done", i, {31'd0, busy_v[i]}, 32'd1);
        end
      end
      if (end_chk) begin
        chk("pending_done", i, exp_q[i].size(), 32'd0);
        chk("pending_write", i, wr_q[i].size(), 32'd0);
      end
    end
  end

  // kind: 0 load, 1 word store, 2 sub-word store, 3 rejected misaligned request
  task automatic issue(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic err, input logic [1:0] sel, input int kind,
                       input logic [31:0] wa, input logic [31:0] wdv);
    exp_t e;
    wr_t  w;
    int   ml;
    int   lat;
    for (int i = 0; i < 2; i++) begin
      ml = (i == 0) ? 1 : 3;
      case (kind)
        0:       lat = ml + 1;
        1:       lat = 2;
        2:       lat = ml + 2;
        default: lat = 1;
      endcase
      e.rdata = exp_rd;
      e.err = err;
      e.sel = sel;
      e.done_cyc = cyc + lat;
      exp_q[i].push_back(e);
      if (kind == 1 || kind == 2) begin
        w.a = wa;
        w.d = wdv;
        wr_q[i].push_back(w);
      end
    end
    is_store = st;
    size = sz;
    addr = a;
    wdata = wd;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (busy_v == 2'b00 && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      n++;
      if (n > 100) begin
        tmo_req = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_chk = 1'b1;
    @(negedge clk);
    #1 rst_chk = 1'b0;
    rst_n = 1'b1;
    init_mem = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    issue(1'b0, 2'b00, 32'h102, 32'h0, 32'h0000_00BB, 1'b0, 2'b00, 0, 32'h0, 32'h0); wait_idle();
    issue(1'b0, 2'b01, 32'h102, 32'h0, 32'h0000_AABB, 1'b0, 2'b01, 0, 32'h0, 32'h0); wait_idle();
    issue(1'b0, 2'b10, 32'h100, 32'h0, 32'hAABB_CCDD, 1'b0, 2'b10, 0, 32'h0, 32'h0); wait_idle();

    // A start arriving two cycles in (RD for the slow DUT, FIN for the fast one) must be dropped.
    issue(1'b0, 2'b00, 32'h101, 32'h0, 32'h0000_00CC, 1'b0, 2'b00, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    is_store = 1'b1; size = 2'b10; addr = 32'h108; wdata = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    issue(1'b1, 2'b01, 32'h102, 32'h9999_1234, 32'h0000_00CC, 1'b0, 2'b01, 2, 32'h100, 32'h1234_CCDD); wait_idle();
    issue(1'b0, 2'b10, 32'h100, 32'h0, 32'h1234_CCDD, 1'b0, 2'b10, 0, 32'h0, 32'h0); wait_idle();
    issue(1'b1, 2'b10, 32'h104, 32'h1122_3344, 32'h1234_CCDD, 1'b0, 2'b10, 1, 32'h104, 32'h1122_3344); wait_idle();
    issue(1'b1, 2'b00, 32'h107, 32'hFFFF_FF5A, 32'h1234_CCDD, 1'b0, 2'b00, 2, 32'h104, 32'h5A22_3344); wait_idle();
    issue(1'b0, 2'b11, 32'h104, 32'h0, 32'h5A22_3344, 1'b0, 2'b10, 0, 32'h0, 32'h0); wait_idle();
`ifdef MISALIGN_CHECK_EN
    issue(1'b0, 2'b01, 32'h101, 32'h0, 32'h5A22_3344, 1'b1, 2'b01, 3, 32'h0, 32'h0); wait_idle();
`else
    issue(1'b0, 2'b01, 32'h101, 32'h0, 32'h0000_CCDD, 1'b0, 2'b01, 0, 32'h0, 32'h0); wait_idle();
`endif

    // Reset while the word store sits in WR: nothing may be written, all outputs return to reset values.
    is_store = 1'b1; size = 2'b10; addr = 32'h108; wdata = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    #1 rst_n = 1'b0;
    rst_chk = 1'b1;
    @(negedge clk);
    #1 rst_chk = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    issue(1'b0, 2'b10, 32'h104, 32'h0, 32'h5A22_3344, 1'b0, 2'b10, 0, 32'h0, 32'h0); wait_idle();
    issue(1'b0, 2'b10, 32'h108, 32'h0, 32'h0000_0000, 1'b0, 2'b10, 0, 32'h0, 32'h0); wait_idle();
    issue(1'b1, 2'b00, 32'h100, 32'h0000_0077, 32'h0000_0000, 1'b0, 2'b00, 2, 32'h100, 32'h1234_CC77); wait_idle();
    issue(1'b0, 2'b01, 32'h100, 32'h0, 32'h0000_CC77, 1'b0, 2'b01, 0, 32'h0, 32'h0); wait_idle();

    repeat (4) @(negedge clk);
    #1 end_chk = 1'b1;
    @(negedge clk);
    #1 end_chk = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
